// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares the single line-wide DataMemory port between two requesters:
//   master 0 = data-cache controller, master 1 = instruction-fetch refill.
// The winning request is latched into the mem_* registers. Those registers
// stay frozen until DataMemory acknowledges. The read line is then returned
// to the winner together with a one-cycle ack.
// A watchdog flags a memory that never answers. The stalled transaction
// keeps waiting; it is not aborted.
//
// States: IDLE -> BUSY (memory request held) -> RELEASE (one idle cycle) -> IDLE
//
// Build option (macro): ARB_ROUND_ROBIN_EN
//   defined   : contention alternates between the masters (1-bit pointer).
//   undefined : fixed priority, master 0 wins contention.
//
// Parameters:
//   ADDR_W   byte address width forwarded to DataMemory
//   DATA_W   line width
//   TIMEOUT  BUSY cycles before err_o sets (2..255, 8-bit watchdog)
//
// Ports:
//   clock_i, rst_i            clock, asynchronous active-high reset
//   mX_req_i/we_i/addr_i/     request, write flag, line address, write line
//   mX_data_i                 (X = 0, 1)
//   mX_data_o                 last read line returned to that master
//   mX_ack_o                  one-cycle completion pulse
//   mem_enable_o/write_o      memory request / write strobe (high only in BUSY)
//   mem_addr_o/mem_data_o     latched line address (low 5 bits zero) / write line
//   mem_data_i/mem_ack_i      memory read line / one-cycle completion
//   err_o                     sticky watchdog flag
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 64
) (
    input  logic              clock_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Per-master inputs gathered into vectors so that selection and
    // per-master return paths can be written once.
    logic [1:0]             req_vec;
    logic [1:0]             we_vec;
    logic [1:0][ADDR_W-1:0] addr_vec;
    logic [1:0][DATA_W-1:0] wdata_vec;
    logic [1:0]             ack_vec;
    logic [1:0][DATA_W-1:0] rdata_vec;

    assign req_vec   = {m1_req_i,  m0_req_i};
    assign we_vec    = {m1_we_i,   m0_we_i};
    assign addr_vec  = {m1_addr_i, m0_addr_i};
    assign wdata_vec = {m1_data_i, m0_data_i};

    // Latched transaction.
    logic              winner_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [7:0]        wdog_reg;
    logic              err_reg;

    // FSM strobes.
    logic latch_en;   // IDLE with a request: capture the winner
    logic done;       // BUSY edge with mem_ack_i: complete the transaction
    logic grant_sel;  // index of the master that wins at this edge

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    // Pointer holds the master preferred on the next contention. It always
    // points away from the most recent winner, so two masters that keep
    // requesting alternate strictly.
    logic rr_ptr_reg;

    always_comb begin
        grant_sel = 1'b0;
        if (m0_req_i && m1_req_i) begin
            grant_sel = rr_ptr_reg;
        end else begin
            grant_sel = !m0_req_i;
        end
    end

    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_reg <= 1'b0;
        end else if (latch_en) begin
            rr_ptr_reg <= !grant_sel;
        end
    end
`else
    // Fixed priority: the data cache wins whenever it is requesting.
    always_comb begin
        grant_sel = !m0_req_i;
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // RELEASE never samples requests. A master that still holds req through
    // its ack cycle therefore cannot be re-granted on that stale request,
    // and DataMemory always sees mem_enable_o drop between transactions.
    always_comb begin
        state_next = state_reg;
        latch_en   = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    state_next = BUSY;
                    latch_en   = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_next = RELEASE;
                    done       = 1'b1;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched request and watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            winner_reg <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            data_reg   <= '0;
            wdog_reg   <= 8'd0;
            err_reg    <= 1'b0;
        end else begin
            if (latch_en) begin
                winner_reg <= grant_sel;
                we_reg     <= we_vec[grant_sel];
                // Line-align: DataMemory only works on whole 32-byte lines.
                addr_reg   <= addr_vec[grant_sel] & ~ADDR_W'(31);
                data_reg   <= wdata_vec[grant_sel];
                wdog_reg   <= 8'd0;
            end else if (state_reg == BUSY && wdog_reg != 8'hFF) begin
                wdog_reg <= wdog_reg + 8'd1;
            end
            // This edge ends the TIMEOUT-th BUSY cycle, so the counter
            // reaches TIMEOUT here.
            if (state_reg == BUSY && wdog_reg == 8'(TIMEOUT - 1)) begin
                err_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-master completion: ack pulse and read-line holding register
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : gen_master
        logic              ack_reg;
        logic [DATA_W-1:0] rdata_reg;
        logic              mine;

        assign mine = done && (winner_reg == 1'(gi));

        always_ff @(posedge clock_i or posedge rst_i) begin
            if (rst_i) begin
                ack_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                ack_reg <= mine;
                // Writes leave the returned line untouched.
                if (mine && !we_reg) begin
                    rdata_reg <= mem_data_i;
                end
            end
        end

        assign ack_vec[gi]   = ack_reg;
        assign rdata_vec[gi] = rdata_reg;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The enable is decoded from the state register, so an asynchronous
    // reset drops it immediately rather than at the next edge.
    assign mem_enable_o = (state_reg == BUSY);
    assign mem_write_o  = (state_reg == BUSY) && we_reg;
    assign mem_addr_o   = addr_reg;
    assign mem_data_o   = data_reg;
    assign m0_ack_o     = ack_vec[0];
    assign m1_ack_o     = ack_vec[1];
    assign m0_data_o    = rdata_vec[0];
    assign m1_data_o    = rdata_vec[1];
    assign err_o        = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. The bench plays DataMemory itself and drives
// mem_ack_i after a chosen latency. A transaction-level model predicts:
// the winner, the line-aligned address, the frozen write line, the returned
// read lines, and the sticky error flag. Set ARB_ROUND_ROBIN_EN at compile
// time to build and check the alternating arbitration policy.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 256;
    localparam int TIMEOUT = 64;

    logic              clock_i = 1'b0;
    logic              rst_i;
    logic              m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
    logic [DATA_W-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
    logic              m0_ack_o, m1_ack_o;
    logic              mem_enable_o, mem_write_o, mem_ack_i, err_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o, mem_data_i;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock_i(clock_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
    );

    always #5 clock_i = ~clock_i;

    int n_cmp = 0;
    int n_mis = 0;

    // Transaction-level model state.
    logic [DATA_W-1:0] exp_rd [2];  // line each master last read
    logic              exp_err;     // sticky watchdog flag
    int                last_win;    // most recent winner; 1 => master 0 preferred next

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_line();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_err   = 1'b0;
        last_win  = 1;
    endtask

    task automatic set_master(input int m, input logic req, input logic we,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (m == 0) begin
            m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_data_i = data;
        end else begin
            m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_data_i = data;
        end
    endtask

    // Runs one transaction from IDLE with the requests currently on the pins.
    // Memory acks at the lat-th edge after the grant. With churn set, both
    // masters' inputs (req included) are scrambled every BUSY cycle.
    // w_obs returns which master the DUT acked (0 or 1).
    task automatic run_txn(input int lat, input logic [DATA_W-1:0] line, input bit churn,
                           output logic w_obs);
        int                w;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wd;
        if (m0_req_i && m1_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = 1 - last_win;
`else
            w = 0;
`endif
        end else begin
            w = m0_req_i ? 0 : 1;
        end
        last_win      = w;
        exp_we        = (w == 0) ? m0_we_i : m1_we_i;
        exp_addr      = (w == 0) ? m0_addr_i : m1_addr_i;
        exp_addr[4:0] = 5'd0;
        exp_wd        = (w == 0) ? m0_data_i : m1_data_i;

        step();
        $display("txn: grant master %0d we=%0b addr=%h lat=%0d", w, exp_we, exp_addr, lat);
        chk1("grant_enable", mem_enable_o, 1'b1);
        chk1("grant_write", mem_write_o, exp_we);
        chkw("grant_addr", DATA_W'(mem_addr_o), DATA_W'(exp_addr));
        chkw("grant_wdata", mem_data_o, exp_wd);
        chk1("grant_no_ack0", m0_ack_o, 1'b0);
        chk1("grant_no_ack1", m1_ack_o, 1'b0);

        for (int i = 1; i < lat; i++) begin
            if (churn) begin
                m0_addr_i = $urandom; m1_addr_i = $urandom;
                m0_data_i = rnd_line(); m1_data_i = rnd_line();
                m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
                m0_req_i = 1'($urandom); m1_req_i = 1'($urandom);
            end
            step();
            if (i >= TIMEOUT) exp_err = 1'b1;
            chk1("busy_enable", mem_enable_o, 1'b1);
            chk1("busy_write", mem_write_o, exp_we);
            chkw("busy_addr", DATA_W'(mem_addr_o), DATA_W'(exp_addr));
            chkw("busy_wdata", mem_data_o, exp_wd);
            chk1("busy_err", err_o, exp_err);
        end

        mem_data_i = line;
        mem_ack_i  = 1'b1;
        step();
        mem_ack_i  = 1'b0;
        mem_data_i = rnd_line();
        if (lat >= TIMEOUT) exp_err = 1'b1;
        if (!exp_we) exp_rd[w] = line;
        w_obs = m1_ack_o;
        chk1("ack0", m0_ack_o, w == 0);
        chk1("ack1", m1_ack_o, w == 1);
        chkw("rdata0", m0_data_o, exp_rd[0]);
        chkw("rdata1", m1_data_o, exp_rd[1]);
        chk1("release_enable", mem_enable_o, 1'b0);
        chk1("release_write", mem_write_o, 1'b0);
        chk1("ack_err", err_o, exp_err);

        step();
        chk1("after_ack0", m0_ack_o, 1'b0);
        chk1("after_ack1", m1_ack_o, 1'b0);
        chk1("after_enable", mem_enable_o, 1'b0);
    endtask

    initial begin
        logic              w_obs;
        logic [DATA_W-1:0] line;
        int                r;

        // ---------------- reset state ----------------
        rst_i = 1'b1;
        mem_ack_i = 1'b0; mem_data_i = '0;
        set_master(0, 1'b0, 1'b0, '0, '0);
        set_master(1, 1'b0, 1'b0, '0, '0);
        model_reset();
        #12;
        chk1("rst_enable", mem_enable_o, 1'b0);
        chk1("rst_write", mem_write_o, 1'b0);
        chkw("rst_addr", DATA_W'(mem_addr_o), '0);
        chkw("rst_wdata", mem_data_o, '0);
        chk1("rst_ack0", m0_ack_o, 1'b0);
        chk1("rst_ack1", m1_ack_o, 1'b0);
        chkw("rst_rdata0", m0_data_o, '0);
        chkw("rst_rdata1", m1_data_o, '0);
        chk1("rst_err", err_o, 1'b0);
        @(negedge clock_i);
        rst_i = 1'b0;
        step();

        // ---------------- single read by m1 ----------------
        set_master(1, 1'b1, 1'b0, 32'h0000_0045, rnd_line());
        line = DATA_W'(8'hA5);
        run_txn(10, line, 1'b0, w_obs);
        chk1("read_winner_m1", w_obs, 1'b1);
        chkw("read_m1_line", m1_data_o, line);
        m1_req_i = 1'b0;

        // ---------------- write with input churn by m0 ----------------
        set_master(0, 1'b1, 1'b1, 32'h0000_0400, {8{32'h1111_1111}});
        run_txn(10, rnd_line(), 1'b1, w_obs);
        chk1("write_winner_m0", w_obs, 1'b0);
        m0_req_i = 1'b0; m1_req_i = 1'b0;

        // ---------------- contention from a fresh reset ----------------
        rst_i = 1'b1;
        #3;
        rst_i = 1'b0;
        model_reset();
        step();
        for (int t = 0; t < 4; t++) begin
            set_master(0, 1'b1, 1'($urandom), $urandom, rnd_line());
            set_master(1, 1'b1, 1'($urandom), $urandom, rnd_line());
            run_txn(int'($urandom_range(12, 1)), rnd_line(), 1'b0, w_obs);
`ifdef ARB_ROUND_ROBIN_EN
            chk1("contention_order", w_obs, (t % 2) == 1);
`else
            chk1("contention_order", w_obs, 1'b0);
`endif
        end

        // ---------------- randomized traffic ----------------
        for (int t = 0; t < 25; t++) begin
            r = int'($urandom_range(3, 1));
            set_master(0, r[0], 1'($urandom), $urandom, rnd_line());
            set_master(1, r[1], 1'($urandom), $urandom, rnd_line());
            run_txn(int'($urandom_range(12, 1)), rnd_line(), 1'($urandom), w_obs);
        end

        // ---------------- stray mem_ack_i in IDLE ----------------
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        $display("txn: stray mem_ack_i while idle");
        chk1("idle_ack0", m0_ack_o, 1'b0);
        chk1("idle_ack1", m1_ack_o, 1'b0);
        chk1("idle_enable", mem_enable_o, 1'b0);
        chk1("idle_err", err_o, 1'b0);
        step();
        chk1("idle_ack0_next", m0_ack_o, 1'b0);
        chk1("idle_ack1_next", m1_ack_o, 1'b0);

        // ---------------- hung memory, late ack at cycle 80 ----------------
        set_master(0, 1'b1, 1'b0, $urandom, rnd_line());
        line = rnd_line();
        run_txn(80, line, 1'b0, w_obs);
        chk1("hung_winner_m0", w_obs, 1'b0);
        chkw("hung_line", m0_data_o, line);
        chk1("hung_err_sticky", err_o, 1'b1);
        m0_req_i = 1'b0;
        step();
        chk1("hung_err_idle", err_o, 1'b1);

        // ---------------- reset in the middle of BUSY ----------------
        set_master(0, 1'b1, 1'b0, $urandom, rnd_line());
        step();
        chk1("midrst_granted", mem_enable_o, 1'b1);
        step(); step(); step();
        #2;
        rst_i = 1'b1;
        #1;
        $display("txn: reset asserted mid-BUSY");
        chk1("midrst_enable_async", mem_enable_o, 1'b0);
        chk1("midrst_err_cleared", err_o, 1'b0);
        mem_ack_i  = 1'b1;
        mem_data_i = rnd_line();
        step();
        mem_ack_i = 1'b0;
        chk1("midrst_no_ack0", m0_ack_o, 1'b0);
        chk1("midrst_no_ack1", m1_ack_o, 1'b0);
        chkw("midrst_rdata0", m0_data_o, '0);
        @(negedge clock_i);
        rst_i = 1'b0;
        model_reset();
        set_master(0, 1'b1, 1'b0, $urandom, rnd_line());
        run_txn(5, rnd_line(), 1'b0, w_obs);
        chk1("post_rst_winner_m0", w_obs, 1'b0);
        m0_req_i = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
